// File: rtl/shift_seq_unit.sv
// Multicycle shifter: picks operand and amount at accept, then moves STEP bits per
// cycle (ROR/SLL/SRL/SRA) and holds the final value in a result register.
module shift_seq_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [1:0]         src_sel,
  input  logic               amt_sel,
  input  logic [SHAMT_W-1:0] in_shamt_field,
  input  logic [DATA_W-1:0]  in_shamt_reg,
  input  logic [DATA_W-1:0]  in_b,
  input  logic [DATA_W-1:0]  in_b_sext,
  input  logic [DATA_W-1:0]  in_num16,
  output logic               busy,
  output logic               done,
  output logic               illegal_sel,
  output logic [DATA_W-1:0]  result
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [1:0]         OP_ROR = 2'b00;
  localparam logic [1:0]         OP_SLL = 2'b01;
  localparam logic [1:0]         OP_SRL = 2'b10;
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [DATA_W-1:0]    work_q, work_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic                 illegal_q, illegal_d;

  logic [DATA_W-1:0]    operand;
  logic [SHAMT_W-1:0]   amount;
  logic [SHAMT_W-1:0]   step_amt;
  logic [DATA_W-1:0]    shifted;
  logic [2*DATA_W-1:0]  ror_dbl;

  // Only the low SHAMT_W bits of the register amount are meaningful.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^in_shamt_reg[DATA_W-1:SHAMT_W];

  always_comb begin
    operand = '0;
    case (src_sel)
      2'b00:   operand = in_b;
      2'b01:   operand = in_b_sext;
      2'b10:   operand = in_num16;
      default: operand = '0;
    endcase
    amount = amt_sel ? in_shamt_reg[SHAMT_W-1:0] : in_shamt_field;
  end

  assign step_amt = (count_q < STEP_C) ? count_q : STEP_C;
  assign ror_dbl  = {work_q, work_q} >> step_amt;

  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_ROR:  shifted = ror_dbl[DATA_W-1:0];
      OP_SLL:  shifted = work_q << step_amt;
      OP_SRL:  shifted = work_q >> step_amt;
      default: shifted = $unsigned($signed(work_q) >>> step_amt);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    result_d  = result_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          work_d    = operand;
          count_d   = amount;
          illegal_d = (src_sel == 2'b11);
          state_d   = (src_sel == 2'b11) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        work_d  = shifted;
        count_d = count_q - step_amt;
        // Amount 0 still spends one SHIFT cycle, shifting by nothing.
        if (count_q <= STEP_C) begin
          state_d  = S_DONE;
          result_d = shifted;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      work_q    <= '0;
      result_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      work_q    <= work_d;
      result_q  <= result_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign illegal_sel = illegal_q;
  assign result      = result_q;

endmodule
